// File: rtl/csr_access_arbiter.sv
// Round-robin arbiter sharing one CSR port among NUM_REQ requesters.
// Optional `CSR_ARB_HOST_PRIO_EN gives requester 0 absolute priority.
module csr_access_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             csr_wen,
  output logic                             csr_ren,
  output logic [ADDR_WIDTH-1:0]            csr_addr,
  output logic [DATA_WIDTH-1:0]            csr_wdata,
  input  logic [DATA_WIDTH-1:0]            csr_rdata,
  output logic                             busy,
  output logic [IDW-1:0]                   grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                  r_state;
  logic [IDW-1:0]          r_rr_ptr;
  logic [IDW-1:0]          r_grant_id;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_wen;
  logic                    r_ren;
  logic [NUM_REQ-1:0]      r_rsp_valid;

  logic [NUM_REQ-1:0]      w_elig;
  logic                    w_host;
  logic [IDW-1:0]          w_hi;
  logic [IDW-1:0]          w_lo;
  logic                    w_hi_found;
  logic [IDW-1:0]          w_win;
  logic                    w_any;
  logic [IDW-1:0]          w_next_ptr;
  logic                    w_win_write;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic [DATA_WIDTH-1:0]   w_win_wdata;
  logic [NUM_REQ-1:0]      w_ready;
  logic [NUM_REQ-1:0]      w_gid_oh;

  // Scanning downwards leaves the lowest eligible index at/after rr_ptr in
  // w_hi and the lowest overall in w_lo (the wrap-around candidate).
  always_comb begin
    w_elig = req_valid;
    w_host = 1'b0;
`ifdef CSR_ARB_HOST_PRIO_EN
    w_host    = req_valid[0];
    w_elig[0] = 1'b0;
`endif
    w_hi       = '0;
    w_lo       = '0;
    w_hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo = IDW'(i);
        if (IDW'(i) >= r_rr_ptr) begin
          w_hi       = IDW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_win = w_host ? '0 : (w_hi_found ? w_hi : w_lo);
    w_any = w_host | (|w_elig);
  end

  always_comb begin
    w_next_ptr = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + IDW'(1);
`ifdef CSR_ARB_HOST_PRIO_EN
    if (w_host) w_next_ptr = r_rr_ptr;
`endif
  end

  always_comb begin
    w_ready     = '0;
    w_gid_oh    = '0;
    w_win_write = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_win_write = req_write[i];
        w_win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_ready[i]  = (r_state == S_IDLE) && w_any;
      end
      w_gid_oh[i] = (r_grant_id == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_write    <= w_win_write;
            r_addr     <= w_win_addr;
            r_wdata    <= w_win_wdata;
            r_grant_id <= w_win;
            r_rr_ptr   <= w_next_ptr;
            r_wen      <= w_win_write;
            r_ren      <= ~w_win_write;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wen       <= 1'b0;
          r_ren       <= 1'b0;
          r_rdata     <= r_write ? '0 : csr_rdata;
          r_rsp_valid <= w_gid_oh;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // r_rsp_valid is one-hot on grant_id, so other rsp_ready bits drop out
          if (|(rsp_ready & r_rsp_valid)) begin
            r_rsp_valid <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign csr_wen   = r_wen;
  assign csr_ren   = r_ren;
  assign csr_addr  = r_addr;
  assign csr_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Randomized bench for csr_access_arbiter against a transaction-level model
// that predicts grants, strobes and responses cycle by cycle.
module tb_csr_access_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [DW-1:0]   rsp_rdata;
  logic            csr_wen, csr_ren;
  logic [AW-1:0]   csr_addr;
  logic [DW-1:0]   csr_wdata;
  logic [DW-1:0]   csr_rdata;
  logic            busy;
  logic [1:0]      grant_id;

  csr_access_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] csr_fn(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5a, a + 8'd1};
  endfunction

  assign csr_rdata = csr_fn(csr_addr);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: phase 0 idle, 1 strobe cycle, 2 awaiting response accept
  int            m_phase, m_ptr, m_gid, hs;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int            seq[$];

  function automatic int winner(input logic [N-1:0] v, input int ptr);
    int idx;
`ifdef CSR_ARB_HOST_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
`ifdef CSR_ARB_HOST_PRIO_EN
      if (idx == 0) continue;
`endif
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic mdl_reset();
    m_phase = 0; m_ptr = 0; m_gid = 0; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; hs = -1;
  endtask

  task automatic mdl_step();
    int w;
    hs = -1;
    case (m_phase)
      0: begin
        w = winner(req_valid, m_ptr);
        if (w >= 0) begin
          m_wr    = req_write[w];
          m_addr  = req_addr[w*AW +: AW];
          m_wdata = req_wdata[w*DW +: DW];
          m_gid   = w;
`ifdef CSR_ARB_HOST_PRIO_EN
          if (w != 0) m_ptr = (w + 1) % N;
`else
          m_ptr = (w + 1) % N;
`endif
          hs      = w;
          m_phase = 1;
        end
      end
      1: begin
        m_rdata = m_wr ? '0 : csr_fn(m_addr);
        m_phase = 2;
      end
      default: if (rsp_ready[m_gid[1:0]]) m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    int w;
    logic [N-1:0] e_ready, e_rsp;
    w = winner(req_valid, m_ptr);
    e_ready = (m_phase == 0 && w >= 0) ? N'(1 << w) : '0;
    e_rsp   = (m_phase == 2) ? N'(1 << m_gid) : '0;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    chk("csr_wen",   64'(csr_wen),   64'(m_phase == 1 && m_wr));
    chk("csr_ren",   64'(csr_ren),   64'(m_phase == 1 && !m_wr));
    chk("csr_addr",  64'(csr_addr),  64'(m_addr));
    chk("csr_wdata", 64'(csr_wdata), 64'(m_wdata));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
    chk("busy",      64'(busy),      64'(m_phase != 0));
    chk("grant_id",  64'(grant_id),  64'(m_gid));
  endtask

  // One cycle: check mid-low-phase, advance model at the edge, retire accepted request
  task automatic cyc();
    #1 check_outputs();
    @(posedge clk);
    mdl_step();
    @(negedge clk);
    if (hs >= 0) req_valid[hs] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rspv"},  64'(rsp_valid), 64'(0));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(0));
    chk({tag, "_strb"},  64'({csr_wen, csr_ren}), 64'(0));
    chk({tag, "_addr"},  64'(csr_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(csr_wdata), 64'(0));
    chk({tag, "_busy"},  64'(busy), 64'(0));
    chk({tag, "_gid"},   64'(grant_id), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    mdl_reset();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0; rsp_ready = '1;
    for (int k = 0; k < 10 && m_phase != 0; k++) cyc();
    chk("drain_idle", 64'(m_phase), 64'(0));
  endtask

  initial begin
    mdl_reset();
    @(negedge clk);
    do_reset();

    // Idle: nothing may happen for 20 cycles
    for (int k = 0; k < 20; k++) cyc();
    chk_zero("idle");

    // Single read from requester 1
    rsp_ready = '1;
    set_req(1, 1'b0, 8'h10, 32'h0);
    cyc();
    chk("t2_ren",  64'(csr_ren), 64'(1));
    chk("t2_addr", 64'(csr_addr), 64'h10);
    cyc();
    chk("t2_rspv",  64'(rsp_valid), 64'(3'b010));
    chk("t2_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    cyc();
    chk("t2_done", 64'(rsp_valid), 64'(0));

    // Single write from requester 0
    set_req(0, 1'b1, 8'h04, 32'hA5A5A5A5);
    cyc();
    chk("t3_wen",   64'({csr_wen, csr_ren}), 64'(2'b10));
    chk("t3_addr",  64'(csr_addr), 64'h04);
    chk("t3_wdata", 64'(csr_wdata), 64'hA5A5A5A5);
    cyc();
    chk("t3_wen_off", 64'(csr_wen), 64'(0));
    chk("t3_rspv",    64'(rsp_valid), 64'(3'b001));
    chk("t3_rdata",   64'(rsp_rdata), 64'(0));
    cyc();

    // All requesters held valid from a fresh pointer
    @(negedge clk);
    do_reset();
    rsp_ready = '1;
    seq.delete();
    for (int k = 0; k < 40 && seq.size() < 6; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) set_req(i, i[0], 8'(8'h20 + i), 32'(k));
      cyc();
      if (hs >= 0) seq.push_back(hs);
    end
    chk("t4_count", 64'(seq.size()), 64'(6));
    for (int k = 0; k < seq.size(); k++) begin
`ifdef CSR_ARB_HOST_PRIO_EN
      chk("t4_grant", 64'(seq[k]), 64'(0));
`else
      chk("t4_grant", 64'(seq[k]), 64'(k % 3));
`endif
    end
    drain();

    // Response backpressure on requester 2
    rsp_ready = 3'b011;
    set_req(2, 1'b0, 8'h22, 32'h0);
    cyc();
    set_req(0, 1'b0, 8'h30, 32'h0);
    set_req(1, 1'b1, 8'h31, 32'h1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t5_busy",  64'(busy), 64'(1));
      chk("t5_rspv",  64'(rsp_valid), 64'(3'b100));
      chk("t5_rdata", 64'(rsp_rdata), 64'(csr_fn(8'h22)));
      chk("t5_noreq", 64'(req_ready), 64'(0));
    end
    rsp_ready = '1;
    for (int k = 0; k < 8; k++) cyc();
    drain();

    // Reset asserted while the strobe is active
    set_req(1, 1'b0, 8'h40, 32'h0);
    cyc();
    chk("t6_ren", 64'(csr_ren), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk_zero("t6");
    @(posedge clk);
    @(negedge clk);
    mdl_reset();
    rst_n = 1'b1;
    chk("t6_rspv", 64'(rsp_valid), 64'(0));
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h50 + i), 32'h0);
    cyc();
    chk("t6_first", 64'(hs), 64'(0));
    drain();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
        else if (req_valid[i] && $urandom_range(0, 15) == 0)
          req_valid[i] = 1'b0;
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
